// File: rtl/cpri_sched_pkg.sv
// Shared definitions for the CPRI TX slot scheduler.
// Holds the default slot and block geometry, and the scheduler FSM state type.
package cpri_sched_pkg;

  localparam int SLOT_LEN_DEF = 480;  // clk cycles per 125 us slot
  localparam int BLK_LEN_DEF  = 96;   // beats per packer block
  localparam int NUM_SLOT_DEF = 80;   // slots per 10 ms frame

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    WAIT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the CPRI TX write path.
// Picks the first channel at or after the pointer that requests and is not masked.
// Ports:
//   req_i     - per-channel request level
//   ptr_i     - round-robin start position
//   mask_i    - channels already served this slot (not eligible)
//   gnt_o     - one-hot grant
//   gnt_idx_o - binary index of the granted channel
//   any_o     - a grant was produced
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int PW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [PW-1:0]     ptr_i,
  input  logic [NUM_CH-1:0] mask_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [PW-1:0]     gnt_idx_o,
  output logic              any_o
);

  logic [NUM_CH-1:0] elig_s;
  int                idx_s;

  assign elig_s = req_i & ~mask_i;

  // Scan from the pointer, wrapping modulo NUM_CH, and keep the first hit.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx_s     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_s = 32'(ptr_i) + i;
      if (idx_s >= NUM_CH) begin
        idx_s = idx_s - NUM_CH;
      end else begin
        idx_s = idx_s;
      end
      if (!any_o && elig_s[idx_s[PW-1:0]]) begin
        gnt_o[idx_s[PW-1:0]] = 1'b1;
        gnt_idx_o            = idx_s[PW-1:0];
        any_o                = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/cpri_tx_sched.sv
// CPRI TX slot scheduler.
// Generates the slot grid and frame slot index, and shares the single CPRI TX
// write path between NUM_CH channel sources, one BLK_LEN-beat block per grant,
// each channel at most once per slot, in round-robin order.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_enable        - run enable (start while idle, stop at slot wrap)
//   i_ch_req        - per-channel block-ready level
//   i_ch_data       - per-channel FIFO data, valid one cycle after o_ch_rd
//   o_ch_rd         - one-hot FIFO pop, BLK_LEN cycles per grant
//   o_cpri_sop      - pulse with beat 0 of each block
//   o_cpri_wvld     - beat valid
//   o_cpri_wdata    - beat data of the granted channel
//   o_iq_tx_enable  - high from the first SOP until the path goes idle
//   o_slot_idx      - current slot 0..NUM_SLOT-1
//   o_slot_sop      - pulse at slot-counter value 0 while running
//   o_drop          - pulse at slot wrap: requesting channels not served
module cpri_tx_sched
  import cpri_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DW       = 64,
  parameter int SLOT_LEN = SLOT_LEN_DEF,
  parameter int BLK_LEN  = BLK_LEN_DEF,
  parameter int NUM_SLOT = NUM_SLOT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [NUM_CH-1:0]    i_ch_req,
  input  logic [NUM_CH*DW-1:0] i_ch_data,
  output logic [NUM_CH-1:0]    o_ch_rd,
  output logic                 o_cpri_sop,
  output logic                 o_cpri_wvld,
  output logic [DW-1:0]        o_cpri_wdata,
  output logic                 o_iq_tx_enable,
  output logic [6:0]           o_slot_idx,
  output logic                 o_slot_sop,
  output logic [NUM_CH-1:0]    o_drop
);

  localparam int CW = $clog2(SLOT_LEN);
  localparam int BW = $clog2(BLK_LEN);
  localparam int PW = $clog2(NUM_CH);

  sched_state_e      state_q, state_d;
  logic              run_q, run_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [6:0]        slot_q, slot_d;
  logic [NUM_CH-1:0] served_q, served_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [BW-1:0]     beat_q, beat_d;

  // Output pipeline: stage 1 aligns with FIFO data, stage 2 is the output register.
  logic              vld1_q, sop1_q;
  logic [PW-1:0]     sel1_q;
  logic              wvld_q, wsop_q;
  logic [DW-1:0]     wdata_q;
  logic              iq_q;
  logic [NUM_CH-1:0] drop_q;

  logic              wrap_s, start_s, last_beat_s;
  logic [NUM_CH-1:0] arb_gnt_s;
  logic [PW-1:0]     arb_idx_s;
  logic              arb_any_s;
  logic [DW-1:0]     ch_data_s [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data_s[k] = i_ch_data[k*DW +: DW];
  end

  assign wrap_s      = run_q && (cyc_q == CW'(SLOT_LEN - 1));
  assign start_s     = (state_q == IDLE) && i_enable;
  assign last_beat_s = (beat_q == BW'(BLK_LEN - 1));

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i     (i_ch_req),
    .ptr_i     (ptr_q),
    .mask_i    (served_q),
    .gnt_o     (arb_gnt_s),
    .gnt_idx_o (arb_idx_s),
    .any_o     (arb_any_s)
  );

  // Slot grid: cycle counter, slot index and run flag.
  always_comb begin
    cyc_d  = cyc_q;
    slot_d = slot_q;
    run_d  = run_q;
    if (start_s) begin
      run_d = 1'b1;
      cyc_d = '0;
    end else if (wrap_s) begin
      cyc_d  = '0;
      slot_d = (slot_q == 7'(NUM_SLOT - 1)) ? 7'd0 : slot_q + 7'd1;
      run_d  = i_enable;
    end else if (run_q) begin
      cyc_d = cyc_q + CW'(1);
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Scheduler FSM next state; a slot wrap overrides everything except a block in flight.
  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    beat_d   = beat_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        if (wrap_s) begin
          state_d = ARB;
        end else if (arb_any_s) begin
          state_d  = XFER;
          gnt_d    = arb_gnt_s;
          gidx_d   = arb_idx_s;
          served_d = served_q | arb_gnt_s;
          ptr_d    = (arb_idx_s == PW'(NUM_CH - 1)) ? '0 : arb_idx_s + PW'(1);
          beat_d   = '0;
        end else begin
          state_d = WAIT;
        end
      end
      XFER: begin
        if (last_beat_s) begin
          // Enable dropped mid-block: finish it, but do not arbitrate again.
          state_d = i_enable ? ARB : WAIT;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      WAIT: begin
        state_d = WAIT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (wrap_s) begin
      served_d = '0;
      if ((state_q != XFER) || last_beat_s) begin
        state_d = i_enable ? ARB : IDLE;
      end else begin
        state_d = state_d;
      end
    end else begin
      served_d = served_d;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      cyc_q    <= '0;
      slot_q   <= '0;
      served_q <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gidx_q   <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      cyc_q    <= cyc_d;
      slot_q   <= slot_d;
      served_q <= served_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      beat_q   <= beat_d;
    end
  end

  // Beat pipeline, IQ enable and drop report.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q  <= 1'b0;
      sop1_q  <= 1'b0;
      sel1_q  <= '0;
      wvld_q  <= 1'b0;
      wsop_q  <= 1'b0;
      wdata_q <= '0;
      iq_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      vld1_q  <= (state_q == XFER);
      sop1_q  <= (state_q == XFER) && (beat_q == '0);
      sel1_q  <= gidx_q;
      wvld_q  <= vld1_q;
      wsop_q  <= sop1_q;
      wdata_q <= vld1_q ? ch_data_s[sel1_q] : '0;
      // Rise with the SOP register; fall once stopping and no beat is left in flight.
      if (sop1_q) begin
        iq_q <= 1'b1;
      end else if ((!run_q || !i_enable) && (state_q != XFER) && !vld1_q) begin
        iq_q <= 1'b0;
      end else begin
        iq_q <= iq_q;
      end
      drop_q <= wrap_s ? (i_ch_req & ~served_q) : '0;
    end
  end

  assign o_ch_rd        = (state_q == XFER) ? gnt_q : '0;
  assign o_cpri_sop     = wsop_q;
  assign o_cpri_wvld    = wvld_q;
  assign o_cpri_wdata   = wdata_q;
  assign o_iq_tx_enable = iq_q;
  assign o_slot_idx     = slot_q;
  assign o_slot_sop     = run_q && (cyc_q == '0);
  assign o_drop         = drop_q;

endmodule

// File: tb/tb_cpri_tx_sched.sv
// Scoreboard bench for cpri_tx_sched: expected beats and drop pulses are queued
// when stimulus is issued and consumed by a monitor on the falling edge.
module tb_cpri_tx_sched;

  typedef struct packed {
    logic        sop;
    logic [63:0] data;
  } beat_t;

  logic         clk;
  logic         rst;
  logic         i_enable;
  logic [3:0]   i_ch_req;
  logic [255:0] ch_data;
  logic [3:0]   o_ch_rd;
  logic         o_cpri_sop;
  logic         o_cpri_wvld;
  logic [63:0]  o_cpri_wdata;
  logic         o_iq_tx_enable;
  logic [6:0]   o_slot_idx;
  logic         o_slot_sop;
  logic [3:0]   o_drop;

  int           n_tests;
  int           n_fail;
  int unsigned  pop_cnt [4];
  int unsigned  exp_cnt [4];
  beat_t        exp_q [$];
  logic [3:0]   drop_q [$];
  beat_t        mon_e;
  logic [3:0]   mon_d;
  int           n;

  cpri_tx_sched dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (i_enable),
    .i_ch_req       (i_ch_req),
    .i_ch_data      (ch_data),
    .o_ch_rd        (o_ch_rd),
    .o_cpri_sop     (o_cpri_sop),
    .o_cpri_wvld    (o_cpri_wvld),
    .o_cpri_wdata   (o_cpri_wdata),
    .o_iq_tx_enable (o_iq_tx_enable),
    .o_slot_idx     (o_slot_idx),
    .o_slot_sop     (o_slot_sop),
    .o_drop         (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel FIFO model: each pop presents {channel, pop count} one cycle later.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        pop_cnt[k] <= 0;
      end else if (o_ch_rd[k]) begin
        ch_data[k*64 +: 64] <= {32'(k), pop_cnt[k]};
        pop_cnt[k]          <= pop_cnt[k] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push_block(input int k);
    for (int b = 0; b < 96; b++) begin
      exp_q.push_back({(b == 0), 32'(k), exp_cnt[k]});
      exp_cnt[k] = exp_cnt[k] + 1;
    end
  endtask

  task automatic wait_slot_sop(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_slot_sop && cyc < 2000);
    if (!o_slot_sop) begin
      n_tests++;
      n_fail++;
      $display("FAIL slot_sop_timeout: got no pulse in %0d cycles, expected one", cyc);
    end
  endtask

  task automatic step(input int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    i_enable = 1'b0;
    i_ch_req = 4'b0000;
    ch_data  = '0;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;

    // Monitor: compare every presented beat and every drop pulse against the queues.
    fork
      forever begin
        @(negedge clk);
        if (o_cpri_wvld) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got data %0h sop %0b, expected no beat", o_cpri_wdata, o_cpri_sop);
          end else begin
            mon_e = exp_q.pop_front();
            if (o_cpri_wdata !== mon_e.data || o_cpri_sop !== mon_e.sop) begin
              n_fail++;
              $display("FAIL beat: got data %0h sop %0b, expected data %0h sop %0b",
                       o_cpri_wdata, o_cpri_sop, mon_e.data, mon_e.sop);
            end
          end
        end
        if (o_drop != 4'b0000) begin
          n_tests++;
          if (drop_q.size() == 0) begin
            n_fail++;
            $display("FAIL drop_unexpected: got %b, expected none", o_drop);
          end else begin
            mon_d = drop_q.pop_front();
            if (o_drop !== mon_d) begin
              n_fail++;
              $display("FAIL drop: got %b, expected %b", o_drop, mon_d);
            end
          end
        end
      end
    join_none

    // Reset state.
    step(3);
    check("rst_ch_rd", 64'(o_ch_rd), 64'd0);
    check("rst_wvld", 64'(o_cpri_wvld), 64'd0);
    check("rst_iq", 64'(o_iq_tx_enable), 64'd0);
    check("rst_slot_idx", 64'(o_slot_idx), 64'd0);
    check("rst_slot_sop", 64'(o_slot_sop), 64'd0);
    check("rst_drop", 64'(o_drop), 64'd0);
    rst = 1'b0;
    step(2);

    // All channels requesting: four blocks per slot in order 0..3.
    i_ch_req = 4'b1111;
    i_enable = 1'b1;
    wait_slot_sop(n);
    check("start_latency", 64'(n), 64'd1);
    check("slot0_idx", 64'(o_slot_idx), 64'd0);
    for (int k = 0; k < 4; k++) push_block(k);
    step(2);
    check("iq_before_sop", 64'(o_iq_tx_enable), 64'd0);
    step(1);
    check("first_sop_cyc3", 64'(o_cpri_sop), 64'd1);
    check("iq_with_sop", 64'(o_iq_tx_enable), 64'd1);
    wait_slot_sop(n);
    check("slot_period", 64'(n), 64'd477);
    check("slot1_idx", 64'(o_slot_idx), 64'd1);
    for (int k = 0; k < 4; k++) push_block(k);
    step(400);

    // Only ch2 requesting: one block per slot, run through the frame wrap.
    i_ch_req = 4'b0100;
    for (int s = 2; s <= 80; s++) begin
      wait_slot_sop(n);
      check("slot_idx", 64'(o_slot_idx), 64'(s % 80));
      if (s > 2) check("slot_period_ch2", 64'(n), 64'd480);
      push_block(2);
    end

    // Late ch1 request after the slot's arbitration: dropped, then served first.
    step(470);
    i_ch_req = 4'b0110;
    drop_q.push_back(4'b0010);
    wait_slot_sop(n);
    check("late_req_period", 64'(n), 64'd10);
    check("late_req_idx", 64'(o_slot_idx), 64'd1);
    push_block(1);

    // Enable drops at beat 40 of the ch1 block: block completes, nothing more.
    step(41);
    i_enable = 1'b0;
    step(57);
    check("last_beat_wvld", 64'(o_cpri_wvld), 64'd1);
    check("last_beat_iq", 64'(o_iq_tx_enable), 64'd1);
    step(1);
    check("after_last_wvld", 64'(o_cpri_wvld), 64'd0);
    check("after_last_iq", 64'(o_iq_tx_enable), 64'd0);
    drop_q.push_back(4'b0100);
    step(381);
    check("stop_no_slot_sop", 64'(o_slot_sop), 64'd0);
    check("stop_slot_idx", 64'(o_slot_idx), 64'd2);
    step(5);
    check("idle_ch_rd", 64'(o_ch_rd), 64'd0);
    check("idle_wvld", 64'(o_cpri_wvld), 64'd0);

    // Restart (pointer at ch2), then reset in the middle of the block.
    i_ch_req = 4'b1111;
    i_enable = 1'b1;
    wait_slot_sop(n);
    check("restart_latency", 64'(n), 64'd1);
    check("restart_idx", 64'(o_slot_idx), 64'd2);
    push_block(2);
    step(51);
    rst      = 1'b1;
    i_enable = 1'b0;
    step(1);
    check("midrst_wvld", 64'(o_cpri_wvld), 64'd0);
    check("midrst_sop", 64'(o_cpri_sop), 64'd0);
    check("midrst_ch_rd", 64'(o_ch_rd), 64'd0);
    check("midrst_iq", 64'(o_iq_tx_enable), 64'd0);
    check("midrst_slot_idx", 64'(o_slot_idx), 64'd0);
    check("midrst_wdata", o_cpri_wdata, 64'd0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    rst = 1'b0;
    step(3);

    // After reset: cycle counter restarts, ch0 first, data {k, beat}.
    i_enable = 1'b1;
    wait_slot_sop(n);
    check("post_rst_latency", 64'(n), 64'd1);
    check("post_rst_idx", 64'(o_slot_idx), 64'd0);
    for (int k = 0; k < 4; k++) push_block(k);
    step(1);
    check("post_rst_rd_ch0", 64'(o_ch_rd), 64'd1);
    step(2);
    check("post_rst_sop", 64'(o_cpri_sop), 64'd1);
    check("post_rst_data0", o_cpri_wdata, 64'd0);
    step(397);
    i_enable = 1'b0;
    step(85);
    check("final_idx", 64'(o_slot_idx), 64'd1);
    check("final_iq", 64'(o_iq_tx_enable), 64'd0);
    check("final_wvld", 64'(o_cpri_wvld), 64'd0);
    check("beats_left", 64'(exp_q.size()), 64'd0);
    check("drops_left", 64'(drop_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
